// File: rtl/poly_pkg.sv
// -----------------------------------------------------------------------------
// poly_pkg
// Shared definitions for the Horner polynomial evaluator:
//   - state_e   : 3-bit FSM state encoding
//   - ALU_ADD / ALU_MUL : operation select codes for poly_mac_alu
//   - deg_width : width of degree / pointer fields for a given MAX_DEG
// -----------------------------------------------------------------------------
package poly_pkg;

    typedef enum logic [2:0] {
        ST_LOAD       = 3'd0,
        ST_LOAD_WAIT  = 3'd1,
        ST_LOADX      = 3'd2,
        ST_LOADX_WAIT = 3'd3,
        ST_MUL        = 3'd4,
        ST_ADD        = 3'd5,
        ST_WRITE      = 3'd6
    } state_e;

    localparam logic ALU_ADD = 1'b0;
    localparam logic ALU_MUL = 1'b1;

    // Bits needed to hold any degree 0..max_deg (never less than one bit).
    function automatic int deg_width(input int max_deg);
        if (max_deg < 1) begin
            return 1;
        end else begin
            return $clog2(max_deg + 1);
        end
    endfunction

endpackage

// File: rtl/poly_mac_alu.sv
// -----------------------------------------------------------------------------
// poly_mac_alu
// Combinational shared datapath for Horner evaluation. Performs either an
// unsigned add or an unsigned multiply, returning the low DATA_W bits and an
// overflow flag (carry out for add, any non-zero upper product bit for mul).
// Ports:
//   a, b      in  DATA_W  operands
//   op        in  1       ALU_ADD (0) or ALU_MUL (1)
//   result    out DATA_W  truncated result
//   overflow  out 1       result did not fit in DATA_W bits
// -----------------------------------------------------------------------------
module poly_mac_alu
    import poly_pkg::*;
#(
    parameter int DATA_W = 8
) (
    input  logic [DATA_W-1:0] a,
    input  logic [DATA_W-1:0] b,
    input  logic              op,
    output logic [DATA_W-1:0] result,
    output logic              overflow
);

    logic [2*DATA_W-1:0] prod_s;
    logic [DATA_W:0]     sum_s;

    // Full-width product and sum, then select by op.
    always_comb begin
        prod_s   = {{DATA_W{1'b0}}, a} * {{DATA_W{1'b0}}, b};
        sum_s    = {1'b0, a} + {1'b0, b};
        result   = sum_s[DATA_W-1:0];
        overflow = sum_s[DATA_W];
        case (op)
            ALU_ADD: begin
                result   = sum_s[DATA_W-1:0];
                overflow = sum_s[DATA_W];
            end
            ALU_MUL: begin
                result   = prod_s[DATA_W-1:0];
                overflow = |prod_s[2*DATA_W-1:DATA_W];
            end
            default: begin
                result   = {DATA_W{1'b0}};
                overflow = 1'b0;
            end
        endcase
    end

endmodule

// File: rtl/poly_horner_eval.sv
// -----------------------------------------------------------------------------
// poly_horner_eval
// Evaluates an unsigned polynomial of runtime degree 0..MAX_DEG at x using
// Horner's method on one shared multiply/add datapath. Coefficients (highest
// order first) and then x are entered one per go press/release.
// Ports:
//   clk          in  1       system clock
//   resetn       in  1       asynchronous active-low reset
//   go           in  1       load strobe (level; one capture per press)
//   deg          in  DEG_W   requested degree, sampled with first coefficient
//   data_in      in  DATA_W  coefficient / x value
//   data_result  out DATA_W  last P(x) mod 2^DATA_W (held between results)
//   ovf          out 1       last evaluation overflowed at some step
//   done         out 1       one-cycle pulse as data_result/ovf update
//   busy         out 1       high during MUL/ADD/WRITE
//   load_ptr     out DEG_W   coefficients already loaded this sequence
//   load_x       out 1       waiting for x
// -----------------------------------------------------------------------------
module poly_horner_eval #(
    parameter int DATA_W  = 8,
    parameter int MAX_DEG = 3,
    parameter int DEG_W   = poly_pkg::deg_width(MAX_DEG)
) (
    input  logic              clk,
    input  logic              resetn,
    input  logic              go,
    input  logic [DEG_W-1:0]  deg,
    input  logic [DATA_W-1:0] data_in,
    output logic [DATA_W-1:0] data_result,
    output logic              ovf,
    output logic              done,
    output logic              busy,
    output logic [DEG_W-1:0]  load_ptr,
    output logic              load_x
);

    import poly_pkg::*;

    state_e              state_q, state_d;
    logic [DEG_W-1:0]    load_ptr_q, load_ptr_d;
    logic [DEG_W-1:0]    deg_l_q, deg_l_d;
    logic [DEG_W-1:0]    i_q, i_d;
    logic [DATA_W-1:0]   x_q, x_d;
    logic [DATA_W-1:0]   acc_q, acc_d;
    logic                ovf_acc_q, ovf_acc_d;
    logic [DATA_W-1:0]   data_result_q, data_result_d;
    logic                ovf_q, ovf_d;
    logic                done_q, done_d;
    logic                busy_q, busy_d;
    logic                load_x_q, load_x_d;
    logic [DATA_W-1:0]   coef_q [0:MAX_DEG];

    logic                coef_we_s;
    logic [DEG_W-1:0]    coef_idx_s;
    logic [DEG_W-1:0]    deg_eff_s;
    logic [DATA_W-1:0]   alu_a_s, alu_b_s, alu_res_s;
    logic                alu_op_s, alu_ovf_s;

    poly_mac_alu #(.DATA_W(DATA_W)) u_alu (
        .a        (alu_a_s),
        .b        (alu_b_s),
        .op       (alu_op_s),
        .result   (alu_res_s),
        .overflow (alu_ovf_s)
    );

    // Effective degree: the first capture of a sequence takes the clamped
    // live deg input (deg_l is written on that same edge), later ones the latch.
    always_comb begin
        deg_eff_s = deg_l_q;
        if (load_ptr_q == {DEG_W{1'b0}}) begin
            if (deg > DEG_W'(MAX_DEG)) begin
                deg_eff_s = DEG_W'(MAX_DEG);
            end else begin
                deg_eff_s = deg;
            end
        end else begin
            deg_eff_s = deg_l_q;
        end
    end

    // Next-state and datapath control.
    always_comb begin
        state_d       = state_q;
        load_ptr_d    = load_ptr_q;
        deg_l_d       = deg_l_q;
        i_d           = i_q;
        x_d           = x_q;
        acc_d         = acc_q;
        ovf_acc_d     = ovf_acc_q;
        data_result_d = data_result_q;
        ovf_d         = ovf_q;
        coef_we_s     = 1'b0;
        coef_idx_s    = {DEG_W{1'b0}};
        alu_a_s       = acc_q;
        alu_b_s       = x_q;
        alu_op_s      = ALU_MUL;

        case (state_q)
            ST_LOAD: begin
                if (go) begin
                    // Coefficients arrive highest order first.
                    coef_we_s  = 1'b1;
                    coef_idx_s = deg_eff_s - load_ptr_q;
                    deg_l_d    = deg_eff_s;
                    state_d    = ST_LOAD_WAIT;
                end else begin
                    state_d = ST_LOAD;
                end
            end
            ST_LOAD_WAIT: begin
                if (!go) begin
                    if (load_ptr_q == deg_l_q) begin
                        state_d = ST_LOADX;
                    end else begin
                        load_ptr_d = load_ptr_q + DEG_W'(1);
                        state_d    = ST_LOAD;
                    end
                end else begin
                    state_d = ST_LOAD_WAIT;
                end
            end
            ST_LOADX: begin
                if (go) begin
                    x_d     = data_in;
                    state_d = ST_LOADX_WAIT;
                end else begin
                    state_d = ST_LOADX;
                end
            end
            ST_LOADX_WAIT: begin
                if (!go) begin
                    acc_d     = coef_q[deg_l_q];
                    i_d       = deg_l_q;
                    ovf_acc_d = 1'b0;
                    if (deg_l_q == {DEG_W{1'b0}}) begin
                        state_d = ST_WRITE;
                    end else begin
                        state_d = ST_MUL;
                    end
                end else begin
                    state_d = ST_LOADX_WAIT;
                end
            end
            ST_MUL: begin
                alu_a_s   = acc_q;
                alu_b_s   = x_q;
                alu_op_s  = ALU_MUL;
                acc_d     = alu_res_s;
                ovf_acc_d = ovf_acc_q | alu_ovf_s;
                i_d       = i_q - DEG_W'(1);
                state_d   = ST_ADD;
            end
            ST_ADD: begin
                // i was already stepped down in MUL, so it names the next term.
                alu_a_s   = acc_q;
                alu_b_s   = coef_q[i_q];
                alu_op_s  = ALU_ADD;
                acc_d     = alu_res_s;
                ovf_acc_d = ovf_acc_q | alu_ovf_s;
                if (i_q == {DEG_W{1'b0}}) begin
                    state_d = ST_WRITE;
                end else begin
                    state_d = ST_MUL;
                end
            end
            ST_WRITE: begin
                data_result_d = acc_q;
                ovf_d         = ovf_acc_q;
                load_ptr_d    = {DEG_W{1'b0}};
                state_d       = ST_LOAD;
            end
            default: begin
                state_d = ST_LOAD;
            end
        endcase

        // Status flags are registered from the upcoming state so they line up
        // with the state they describe; done lands with the result update.
        done_d   = (state_q == ST_WRITE);
        busy_d   = (state_d == ST_MUL) || (state_d == ST_ADD) || (state_d == ST_WRITE);
        load_x_d = (state_d == ST_LOADX) || (state_d == ST_LOADX_WAIT);
    end

    // Control, datapath and output registers.
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            state_q       <= ST_LOAD;
            load_ptr_q    <= {DEG_W{1'b0}};
            deg_l_q       <= {DEG_W{1'b0}};
            i_q           <= {DEG_W{1'b0}};
            x_q           <= {DATA_W{1'b0}};
            acc_q         <= {DATA_W{1'b0}};
            ovf_acc_q     <= 1'b0;
            data_result_q <= {DATA_W{1'b0}};
            ovf_q         <= 1'b0;
            done_q        <= 1'b0;
            busy_q        <= 1'b0;
            load_x_q      <= 1'b0;
        end else begin
            state_q       <= state_d;
            load_ptr_q    <= load_ptr_d;
            deg_l_q       <= deg_l_d;
            i_q           <= i_d;
            x_q           <= x_d;
            acc_q         <= acc_d;
            ovf_acc_q     <= ovf_acc_d;
            data_result_q <= data_result_d;
            ovf_q         <= ovf_d;
            done_q        <= done_d;
            busy_q        <= busy_d;
            load_x_q      <= load_x_d;
        end
    end

    // Coefficient register file.
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            for (int k = 0; k <= MAX_DEG; k++) begin
                coef_q[k] <= {DATA_W{1'b0}};
            end
        end else if (coef_we_s) begin
            coef_q[coef_idx_s] <= data_in;
        end
    end

    assign data_result = data_result_q;
    assign ovf         = ovf_q;
    assign done        = done_q;
    assign busy        = busy_q;
    assign load_ptr    = load_ptr_q;
    assign load_x      = load_x_q;

endmodule

// File: tb/tb_poly_horner_eval.sv
// -----------------------------------------------------------------------------
// tb_poly_horner_eval
// Directed bench for poly_horner_eval (DATA_W=8, MAX_DEG=3). Each sequence
// loads coefficients highest order first, then x, and compares result, ovf,
// latency, busy length and load_ptr/load_x progress with hand-computed values.
// -----------------------------------------------------------------------------
module tb_poly_horner_eval;

    logic       clk;
    logic       resetn;
    logic       go;
    logic [1:0] deg;
    logic [7:0] data_in;
    logic [7:0] data_result;
    logic       ovf;
    logic       done;
    logic       busy;
    logic [1:0] load_ptr;
    logic       load_x;

    int checks;
    int failures;
    logic [7:0] prev_res;
    logic       prev_ovf;

    poly_horner_eval #(.DATA_W(8), .MAX_DEG(3)) dut (
        .clk         (clk),
        .resetn      (resetn),
        .go          (go),
        .deg         (deg),
        .data_in     (data_in),
        .data_result (data_result),
        .ovf         (ovf),
        .done        (done),
        .busy        (busy),
        .load_ptr    (load_ptr),
        .load_x      (load_x)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s got=0x%0h exp=0x%0h", tag, got, exp);
        end
    endtask

    // Hold go high across 'hold' rising edges, then release for one edge.
    task automatic press(input logic [7:0] v, input int hold);
        data_in = v;
        go      = 1'b1;
        repeat (hold) @(negedge clk);
        go = 1'b0;
        @(negedge clk);
    endtask

    // cvec holds up to four coefficients, first-entered (highest order) in [31:24].
    task automatic run_seq(input string tag, input int d, input logic [31:0] cvec,
                           input logic [7:0] x, input int hold, input bit toggle,
                           input logic [7:0] exp_res, input logic exp_ovf);
        int cyc;
        int busy_cnt;
        deg = 2'(d);
        for (int k = 0; k <= d; k++) begin
            press(cvec[31-8*k -: 8], hold);
            if (k == 0) begin
                check_eq({tag, "_hold_res"}, 32'(data_result), 32'(prev_res));
                check_eq({tag, "_hold_ovf"}, 32'(ovf), 32'(prev_ovf));
            end
            check_eq({tag, "_load_ptr"}, 32'(load_ptr), (k < d) ? 32'(k + 1) : 32'(d));
            check_eq({tag, "_load_x"}, 32'(load_x), (k == d) ? 32'd1 : 32'd0);
        end
        press(x, hold);
        cyc      = 0;
        busy_cnt = 0;
        while (!done && cyc < 50) begin
            if (busy) busy_cnt++;
            if (toggle) go = (cyc == 0 || cyc == 2) ? 1'b1 : 1'b0;
            @(negedge clk);
            cyc++;
        end
        go = 1'b0;
        check_eq({tag, "_latency"}, 32'(cyc), 32'(2 * d + 1));
        check_eq({tag, "_busy_len"}, 32'(busy_cnt), 32'(2 * d + 1));
        check_eq({tag, "_result"}, 32'(data_result), 32'(exp_res));
        check_eq({tag, "_ovf"}, 32'(ovf), 32'(exp_ovf));
        @(negedge clk);
        check_eq({tag, "_done_pulse"}, 32'(done), 32'd0);
        check_eq({tag, "_ptr_clear"}, 32'(load_ptr), 32'd0);
        prev_res = exp_res;
        prev_ovf = exp_ovf;
    endtask

    initial begin
        int seen_done;
        checks   = 0;
        failures = 0;
        prev_res = 8'h00;
        prev_ovf = 1'b0;
        resetn   = 1'b0;
        go       = 1'b0;
        deg      = 2'd0;
        data_in  = 8'h00;
        repeat (3) @(negedge clk);
        check_eq("rst_result", 32'(data_result), 32'd0);
        check_eq("rst_ovf", 32'(ovf), 32'd0);
        check_eq("rst_done", 32'(done), 32'd0);
        check_eq("rst_busy", 32'(busy), 32'd0);
        check_eq("rst_load_ptr", 32'(load_ptr), 32'd0);
        check_eq("rst_load_x", 32'(load_x), 32'd0);
        resetn = 1'b1;
        @(negedge clk);

        // 1*16 + 2*4 + 3 = 27
        run_seq("deg2", 2, {8'd1, 8'd2, 8'd3, 8'd0}, 8'd4, 1, 1'b0, 8'h1B, 1'b0);
        // 7^3 = 343 -> 0x57, multiply overflow
        run_seq("deg3_ovf", 3, {8'd1, 8'd0, 8'd0, 8'd0}, 8'd7, 1, 1'b0, 8'h57, 1'b1);
        // constant polynomial
        run_seq("deg0", 0, {8'h2A, 8'h00, 8'h00, 8'h00}, 8'h09, 1, 1'b0, 8'h2A, 1'b0);
        // 0*27 + 0*9 + 1*3 + 5 = 8 at the maximum degree
        run_seq("deg3_max", 3, {8'd0, 8'd0, 8'd1, 8'd5}, 8'd3, 1, 1'b0, 8'h08, 1'b0);
        // long holds plus go toggling while computing: 3*25 + 20*5 + 30 = 205
        run_seq("hold_tog", 2, {8'd3, 8'd20, 8'd30, 8'd0}, 8'd5, 20, 1'b1, 8'hCD, 1'b0);
        // add carry only: 0xF0*1 + 0x20 = 0x110 -> 0x10
        run_seq("add_carry", 1, {8'hF0, 8'h20, 8'h00, 8'h00}, 8'd1, 1, 1'b0, 8'h10, 1'b1);

        // Abort a sequence with an asynchronous reset while in ADD.
        deg = 2'd2;
        press(8'd1, 1);
        press(8'd2, 1);
        press(8'd3, 1);
        press(8'd4, 1);
        @(negedge clk);
        #2 resetn = 1'b0;
        #1;
        check_eq("arst_result", 32'(data_result), 32'd0);
        check_eq("arst_ovf", 32'(ovf), 32'd0);
        check_eq("arst_busy", 32'(busy), 32'd0);
        check_eq("arst_load_ptr", 32'(load_ptr), 32'd0);
        check_eq("arst_load_x", 32'(load_x), 32'd0);
        seen_done = 0;
        repeat (3) begin
            @(negedge clk);
            if (done) seen_done++;
        end
        resetn = 1'b1;
        repeat (6) begin
            @(negedge clk);
            if (done) seen_done++;
        end
        check_eq("arst_no_done", 32'(seen_done), 32'd0);
        prev_res = 8'h00;
        prev_ovf = 1'b0;
        // ((1*2 + 2)*2 + 3)*2 + 4 = 26
        run_seq("post_rst", 3, {8'd1, 8'd2, 8'd3, 8'd4}, 8'd2, 1, 1'b0, 8'h1A, 1'b0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
